dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-ported synchronous data memory of the Riscv151 core. It shares the dmem port between the CPU load/store path and a DMA/UART-loader requester. CPU has fixed priority. A wait counter guarantees the DMA side a slot after a bounded stall. Read data returns one cycle after grant, steered by a registered owner tag.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the Riscv151 data-memory arbiter.
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W = 14;
   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned WAIT_W      = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   typedef enum logic {
      PRIO_CPU = 1'b0,
      PRIO_DMA = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the CPU (fixed priority) and a DMA/loader
// requester; a wait counter promotes a starved DMA request for one grant.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W   = DMEM_ADDR_W,
   parameter int unsigned DATA_W   = DMEM_DATA_W,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cpu_req,
   input  logic [3:0]        cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,

   input  logic              dma_req,
   input  logic [3:0]        dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,

   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              dma_promoted
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   arb_state_t        state_q, state_d;
   owner_t            rd_owner_q, rd_owner_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Same-cycle grants; held off entirely while reset is asserted.
   always_comb begin
      cpu_gnt = rst_n & cpu_req & ((state_q == PRIO_CPU) | ~dma_req);
      dma_gnt = rst_n & dma_req & ((state_q == PRIO_DMA) | ~cpu_req);
   end

   // Memory port mux; all fields zero when nobody is granted.
   always_comb begin
      mem_en    = cpu_gnt | dma_gnt;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_gnt) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   // Next state, starvation counter and read-owner tag.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      rd_owner_d = OWN_NONE;

      if (dma_req && !dma_gnt) begin
         wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
      end

      case (state_q)
         PRIO_CPU: if (dma_req && !dma_gnt && wait_cnt_d == MAX_WAIT_C) state_d = PRIO_DMA;
         PRIO_DMA: if (dma_gnt || !dma_req) state_d = PRIO_CPU;
         default:  state_d = PRIO_CPU;
      endcase

      if (cpu_gnt && cpu_we == 4'd0) begin
         rd_owner_d = OWN_CPU;
      end else if (dma_gnt && dma_we == 4'd0) begin
         rd_owner_d = OWN_DMA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PRIO_CPU;
         wait_cnt_q <= '0;
         rd_owner_q <= OWN_NONE;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   assign cpu_rvalid   = (rd_owner_q == OWN_CPU);
   assign dma_rvalid   = (rd_owner_q == OWN_DMA);
   assign cpu_rdata    = mem_rdata;
   assign dma_rdata    = mem_rdata;
   assign dma_promoted = (state_q == PRIO_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, corner-case
// sequences and a randomized run against a queue-free behavioural model.
module tb_dmem_arbiter;

   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, dma_req;
   logic [3:0]    cpu_we, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [DW-1:0] cpu_rdata, dma_rdata;
   logic          mem_en;
   logic [3:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          dma_promoted;

   // Second instance with MAX_WAIT=1 sharing the stimulus.
   logic          u1_cpu_gnt, u1_cpu_rvalid, u1_dma_gnt, u1_dma_rvalid;
   logic [DW-1:0] u1_cpu_rdata, u1_dma_rdata;
   logic          u1_mem_en;
   logic [3:0]    u1_mem_we;
   logic [AW-1:0] u1_mem_addr;
   logic [DW-1:0] u1_mem_wdata;
   logic          u1_dma_promoted;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dma_promoted(dma_promoted)
   );

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(u1_cpu_gnt), .cpu_rvalid(u1_cpu_rvalid), .cpu_rdata(u1_cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(u1_dma_gnt), .dma_rvalid(u1_dma_rvalid), .dma_rdata(u1_dma_rdata),
      .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
      .mem_rdata(mem_rdata), .dma_promoted(u1_dma_promoted)
   );

   // Synchronous single-port memory, 16 words deep.
   logic [DW-1:0] tmem [16];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'd0) mem_rdata <= tmem[mem_addr[3:0]];
         else for (int b = 0; b < 4; b++)
            if (mem_we[b]) tmem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic cr, input logic [3:0] cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic dr, input logic [3:0] dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cpu_gnt"}, 64'(cpu_gnt), 64'd0);
      chk({tag, "_dma_gnt"}, 64'(dma_gnt), 64'd0);
      chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
      chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      chk({tag, "_cpu_rvalid"}, 64'(cpu_rvalid), 64'd0);
      chk({tag, "_dma_rvalid"}, 64'(dma_rvalid), 64'd0);
      chk({tag, "_promoted"}, 64'(dma_promoted), 64'd0);
      chk({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'(mem_rdata));
   endtask

   // Behavioural model: DMA wins a conflict once it has been refused MW times in a row.
   int            denials = 0;
   int            exp_rd = 0;          // 0 none, 1 cpu, 2 dma
   logic [DW-1:0] exp_rdata = '0;
   logic [DW-1:0] shadow [16];
   logic          last_cg, last_dg;

   task automatic mcycle();
      logic          dwin, ecg, edg;
      logic [3:0]    ewe;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ewd;
      #1;
      dwin = (denials >= int'(MW));
      ecg  = cpu_req && (!dma_req || !dwin);
      edg  = dma_req && (!cpu_req || dwin);
      ewe = ecg ? cpu_we : (edg ? dma_we : 4'd0);
      eaddr = ecg ? cpu_addr : (edg ? dma_addr : '0);
      ewd = ecg ? cpu_wdata : (edg ? dma_wdata : '0);
      chk("rnd_cpu_gnt", 64'(cpu_gnt), 64'(ecg));
      chk("rnd_dma_gnt", 64'(dma_gnt), 64'(edg));
      chk("rnd_mem_en", 64'(mem_en), 64'(ecg | edg));
      chk("rnd_mem_we", 64'(mem_we), 64'(ewe));
      chk("rnd_mem_addr", 64'(mem_addr), 64'(eaddr));
      chk("rnd_mem_wdata", 64'(mem_wdata), 64'(ewd));
      chk("rnd_promoted", 64'(dma_promoted), 64'(dwin));
      chk("rnd_cpu_rvalid", 64'(cpu_rvalid), 64'(exp_rd == 1));
      chk("rnd_dma_rvalid", 64'(dma_rvalid), 64'(exp_rd == 2));
      if (exp_rd == 1) chk("rnd_cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
      if (exp_rd == 2) chk("rnd_dma_rdata", 64'(dma_rdata), 64'(exp_rdata));
      last_cg = ecg;
      last_dg = edg;
      @(posedge clk);
      exp_rd = 0;
      if (ecg || edg) begin
         if (ewe == 4'd0) begin
            exp_rd    = ecg ? 1 : 2;
            exp_rdata = shadow[eaddr[3:0]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (ewe[b]) shadow[eaddr[3:0]][8*b +: 8] = ewd[8*b +: 8];
         end
      end
      if (dma_req && !edg) denials = (denials < int'(MW)) ? denials + 1 : denials;
      else denials = 0;
      @(negedge clk);
   endtask

   typedef struct {
      logic          creq;  logic [3:0] cwe; logic [AW-1:0] caddr; logic [DW-1:0] cwd;
      logic          dreq;  logic [3:0] dwe; logic [AW-1:0] daddr; logic [DW-1:0] dwd;
      logic          e_cg;  logic e_dg; logic [3:0] e_mwe;
      logic          e_crv; logic e_drv; logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{1'b1, 4'hF, 14'd5, 32'h11223344, 1'b0, 4'h0, 14'd0, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 4'hF, 14'd9, 32'h55667788, 1'b0, 4'h0, 14'd0, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{1'b1, 4'h0, 14'd5, 32'h0,        1'b0, 4'h0, 14'd0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 4'h0, 14'd0, 32'h0,        1'b0, 4'h0, 14'd0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h11223344};
      vecs[4] = '{1'b1, 4'hF, 14'd7, 32'hAABBCCDD, 1'b1, 4'h0, 14'd7, 32'h0, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 4'h0, 14'd0, 32'h0,        1'b1, 4'h0, 14'd7, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 4'h0, 14'd0, 32'h0,        1'b0, 4'h0, 14'd0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 32'hAABBCCDD};
      vecs[7] = '{1'b1, 4'h4, 14'd9, 32'h00EE0000, 1'b0, 4'h0, 14'd0, 32'h0, 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 32'h0};
      vecs[8] = '{1'b1, 4'h0, 14'd9, 32'h0,        1'b0, 4'h0, 14'd0, 32'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
      vecs[9] = '{1'b0, 4'h0, 14'd0, 32'h0,        1'b0, 4'h0, 14'd0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h55EE7788};

      rst_n = 1'b0;
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      @(negedge clk); @(negedge clk);
      #1 chk_reset_outputs("reset_idle");
      drive(1'b1, 4'h0, 14'd3, 32'h1, 1'b1, 4'hF, 14'd4, 32'h2);
      #1 chk_reset_outputs("reset_req");
      @(negedge clk);
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
               vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
         #1;
         chk($sformatf("vec%0d_cpu_gnt", i), 64'(cpu_gnt), 64'(vecs[i].e_cg));
         chk($sformatf("vec%0d_dma_gnt", i), 64'(dma_gnt), 64'(vecs[i].e_dg));
         chk($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].e_mwe));
         chk($sformatf("vec%0d_cpu_rvalid", i), 64'(cpu_rvalid), 64'(vecs[i].e_crv));
         chk($sformatf("vec%0d_dma_rvalid", i), 64'(dma_rvalid), 64'(vecs[i].e_drv));
         if (vecs[i].e_crv) chk($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].e_rdata));
         if (vecs[i].e_drv) chk($sformatf("vec%0d_dma_rdata", i), 64'(dma_rdata), 64'(vecs[i].e_rdata));
         @(negedge clk);
      end

      // Promotion under continuous CPU traffic; second instance checks MAX_WAIT=1.
      for (int k = 0; k <= 9; k++) begin
         drive(1'b1, 4'h0, 14'd1, '0, k <= 8, 4'h0, 14'd2, '0);
         #1;
         chk($sformatf("promo%0d_cpu_gnt", k), 64'(cpu_gnt), 64'(k != 8));
         chk($sformatf("promo%0d_dma_gnt", k), 64'(dma_gnt), 64'(k == 8));
         chk($sformatf("promo%0d_promoted", k), 64'(dma_promoted), 64'(k == 8));
         chk($sformatf("mw1_%0d_dma_gnt", k), 64'(u1_dma_gnt), 64'((k % 2 == 1) && k <= 8));
         chk($sformatf("mw1_%0d_cpu_gnt", k), 64'(u1_cpu_gnt), 64'(!((k % 2 == 1) && k <= 8)));
         chk($sformatf("mw1_%0d_promoted", k), 64'(u1_dma_promoted), 64'(k % 2 == 1));
         @(negedge clk);
      end
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);

      // DMA drops its request while promoted: counter restarts from zero.
      for (int k = 0; k <= 17; k++) begin
         drive(1'b1, 4'h0, 14'd1, '0, k != 8, 4'h0, 14'd2, '0);
         #1;
         chk($sformatf("drop%0d_promoted", k), 64'(dma_promoted), 64'(k == 8 || k == 17));
         chk($sformatf("drop%0d_dma_gnt", k), 64'(dma_gnt), 64'(k == 17));
         chk($sformatf("drop%0d_cpu_gnt", k), 64'(cpu_gnt), 64'(k != 17));
         @(negedge clk);
      end
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);

      // Reset lands between a CPU read grant and its data return.
      drive(1'b1, 4'h0, 14'd5, '0, 1'b0, 4'h0, '0, '0);
      #1 chk("rstmid_cpu_gnt", 64'(cpu_gnt), 64'd1);
      #2 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk_reset_outputs($sformatf("rstmid%0d", k));
      end
      @(negedge clk);
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #1 chk($sformatf("rstrel%0d_cpu_rvalid", k), 64'(cpu_rvalid), 64'd0);
         @(negedge clk);
      end

      // Randomized run: preload every model word through the CPU port, then mix traffic.
      denials = 0;
      exp_rd = 0;
      for (int a = 0; a < 16; a++) begin
         drive(1'b1, 4'hF, AW'(a), $urandom, 1'b0, 4'h0, '0, '0);
         mcycle();
      end
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      last_cg = 1'b1;
      last_dg = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!cpu_req || last_cg) begin
            cpu_req   = ($urandom % 3) != 0;
            cpu_we    = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            cpu_addr  = AW'($urandom_range(0, 15));
            cpu_wdata = $urandom;
         end
         if (!dma_req || last_dg || ($urandom % 8) == 0) begin
            dma_req   = ($urandom % 2) != 0;
            dma_we    = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            dma_addr  = AW'($urandom_range(0, 15));
            dma_wdata = $urandom;
         end
         mcycle();
      end
      drive(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
      mcycle();
      mcycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
